// File: rtl/dadda_mac_acc_if.sv
// Operand-stream / frame-result handshake bundle for dadda_mac_acc.
// The master drives operands and out_ready; the slave (the MAC) drives
// in_ready and the frame result.
interface dadda_mac_acc_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/dadda_mac_acc.sv
// Pipelined 8x8 multiply-accumulate over in_last-delimited frames.
//   S1: operand capture, S2: Dadda product, S3: accumulator.
// A small FSM stops intake after the last beat, lets the pipe drain and
// then holds the frame result until the consumer takes it.

// Combinational 8x8 unsigned Dadda multiplier. Partial-product columns are
// reduced with full/half adders to the Dadda heights 6,4,3,2, then the two
// remaining rows are summed by a single carry-propagate add.
module dadda_final (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  localparam int NC = 16;  // product columns
  localparam int MH = 8;   // tallest column (8 partial products)

  // Target column height after each reduction stage.
  function automatic int dadda_target(input int s);
    case (s)
      0:       return 6;
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  logic [15:0] w_row0;
  logic [15:0] w_row1;

  // Build the partial-product matrix and compress it column by column.
  // One spare column on top keeps the carry index in range; it never
  // receives a bit because the product fits in 16 bits.
  always_comb begin
    logic [MH-1:0] cur [NC+1];
    logic [MH-1:0] nxt [NC+1];
    int            hc  [NC+1];
    int            hn  [NC+1];
    int            idx;
    int            rem;
    int            d;

    idx = 0;
    rem = 0;
    d   = 0;
    for (int i = 0; i <= NC; i++) begin
      cur[i] = '0;
      nxt[i] = '0;
      hc[i]  = 0;
      hn[i]  = 0;
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        cur[i+j][hc[i+j]] = i_a[i] & i_b[j];
        hc[i+j] = hc[i+j] + 1;
      end
    end

    for (int s = 0; s < 4; s++) begin
      d = dadda_target(s);
      for (int i = 0; i <= NC; i++) begin
        nxt[i] = '0;
        hn[i]  = 0;
      end
      for (int i = 0; i < NC; i++) begin
        idx = 0;
        // Only compress as much as needed to hit the target height,
        // counting carries already pushed in from the column below.
        for (int k = 0; k < 4; k++) begin
          rem = hc[i] - idx + hn[i];
          if (rem > d) begin
            if ((rem - d >= 2) && (hc[i] - idx >= 3)) begin
              nxt[i][hn[i]] = cur[i][idx] ^ cur[i][idx+1] ^ cur[i][idx+2];
              hn[i] = hn[i] + 1;
              nxt[i+1][hn[i+1]] = (cur[i][idx]   & cur[i][idx+1]) |
                                  (cur[i][idx]   & cur[i][idx+2]) |
                                  (cur[i][idx+1] & cur[i][idx+2]);
              hn[i+1] = hn[i+1] + 1;
              idx = idx + 3;
            end else if (hc[i] - idx >= 2) begin
              nxt[i][hn[i]] = cur[i][idx] ^ cur[i][idx+1];
              hn[i] = hn[i] + 1;
              nxt[i+1][hn[i+1]] = cur[i][idx] & cur[i][idx+1];
              hn[i+1] = hn[i+1] + 1;
              idx = idx + 2;
            end
          end
        end
        // Untouched bits pass straight through to the next stage.
        for (int j = 0; j < MH; j++) begin
          if ((j >= idx) && (j < hc[i])) begin
            nxt[i][hn[i]] = cur[i][j];
            hn[i] = hn[i] + 1;
          end
        end
      end
      cur = nxt;
      hc  = hn;
    end

    w_row0 = '0;
    w_row1 = '0;
    for (int i = 0; i < NC; i++) begin
      w_row0[i] = cur[i][0];
      w_row1[i] = cur[i][1];
    end
  end

  assign o_p = w_row0 + w_row1;
endmodule

module dadda_mac_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  dadda_mac_acc_if.slave bus
);
  localparam int STAGES = 2;  // valid-carrying registers ahead of the accumulator

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_OUT
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [STAGES:1]  r_vld_pipe;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [15:0]      w_prod;
  logic [15:0]      r_prod;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_first;
  logic             w_accept;
  logic             w_out_hs;
  logic [ACC_W:0]   w_sum;

  // Handshakes use only registered ready/valid, so neither output depends
  // combinationally on in_valid or out_ready.
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_out_hs = bus.out_ready & r_out_valid;

  dadda_final u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  // Frame control: the end of a frame is tracked here from the accepted
  // in_last, so last does not need to travel down the data pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCEPT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_accept && bus.in_last) begin
            r_state    <= ST_DRAIN1;
            r_in_ready <= 1'b0;
          end
        end
        ST_DRAIN1: r_state <= ST_DRAIN2;
        ST_DRAIN2: begin
          r_state     <= ST_OUT;
          r_out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_state     <= ST_ACCEPT;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_ACCEPT;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // S1/S2 data path: operands only load on an accepted beat, so idle-cycle
  // garbage never reaches the multiplier; valid bits shift alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_prod     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
      if (w_accept) begin
        r_a <= bus.in_a;
        r_b <= bus.in_b;
      end
      if (r_vld_pipe[1]) r_prod <= w_prod;
    end
  end

  // One ACC_W-bit add; the extra top bit is the carry-out that feeds ovf.
  assign w_sum = {1'b0, r_acc} + {1'b0, ACC_W'(r_prod)};

  // S3 accumulator. The first term of a frame overwrites rather than adds,
  // which clears the previous frame's result without a separate cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_first <= 1'b1;
    end else if (r_vld_pipe[STAGES]) begin
      r_first <= 1'b0;
      if (r_first) begin
        r_acc <= ACC_W'(r_prod);
        r_cnt <= CNT_W'(1);
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end else if (w_out_hs) begin
      r_first <= 1'b1;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_dadda_mac_acc.sv
// Directed bench for dadda_mac_acc. Two instances (24-bit and 16-bit
// accumulators) see identical stimulus; a behavioural frame model pushes
// expected results per instance and they are popped at each output.
module tb_dadda_mac_acc;
  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_last   = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_a      = '0;
  logic [7:0] in_b      = '0;

  int n_vec = 0;
  int n_err = 0;

  longint m_sum = 0;
  int     m_cnt = 0;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cnt;
    logic [31:0] ovf;
  } exp_t;

  exp_t q24[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  dadda_mac_acc_if #(.ACC_W(24), .CNT_W(8)) b24 ();
  dadda_mac_acc_if #(.ACC_W(16), .CNT_W(8)) b16 ();

  assign b24.in_valid  = in_valid;
  assign b24.in_a      = in_a;
  assign b24.in_b      = in_b;
  assign b24.in_last   = in_last;
  assign b24.out_ready = out_ready;
  assign b16.in_valid  = in_valid;
  assign b16.in_a      = in_a;
  assign b16.in_b      = in_b;
  assign b16.in_last   = in_last;
  assign b16.out_ready = out_ready;

  dadda_mac_acc #(.ACC_W(24), .CNT_W(8)) dut24 (.clk(clk), .rst_n(rst_n), .bus(b24));
  dadda_mac_acc #(.ACC_W(16), .CNT_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Close the modelled frame and queue its expected result for both widths.
  task automatic push_frame();
    exp_t e;
    e.cnt = (m_cnt > 255) ? 32'd255 : 32'(m_cnt);
    e.sum = 32'(m_sum % 64'd16777216);
    e.ovf = (m_sum >= 64'd16777216) ? 32'd1 : 32'd0;
    q24.push_back(e);
    e.sum = 32'(m_sum % 64'd65536);
    e.ovf = (m_sum >= 64'd65536) ? 32'd1 : 32'd0;
    q16.push_back(e);
    m_sum = 0;
    m_cnt = 0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    @(negedge clk);
    chk("in_ready24_beat", 32'(b24.in_ready), 32'd1);
    chk("in_ready16_beat", 32'(b16.in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    m_sum    = m_sum + longint'(a) * longint'(b);
    m_cnt++;
    if (last) push_frame();
  endtask

  task automatic bubble();
    @(negedge clk);
    chk("in_ready24_bubble", 32'(b24.in_ready), 32'd1);
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_last  = 1'b1;
  endtask

  // Call right after the last beat: checks drain latency, holds OUT for
  // 'hold' extra cycles with out_ready low, then completes the handshake.
  task automatic expect_out(input int hold);
    exp_t e24;
    exp_t e16;
    int   n;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_valid  = 1'b0;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        in_last   = 1'b0;
        out_ready = (hold == 0);
      end
      if (b24.out_valid) begin
        n = i;
        break;
      end
      chk("in_ready24_drain", 32'(b24.in_ready), 32'd0);
      chk("in_ready16_drain", 32'(b16.in_ready), 32'd0);
    end
    chk("latency24", 32'(n), 32'd3);
    chk("out_valid16", 32'(b16.out_valid), 32'd1);
    e24 = '{default: '0};
    e16 = '{default: '0};
    if (q24.size() > 0) e24 = q24.pop_front();
    if (q16.size() > 0) e16 = q16.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("out_valid24_hold", 32'(b24.out_valid), 32'd1);
      chk("in_ready24_out",   32'(b24.in_ready),  32'd0);
      chk("sum24",   32'(b24.out_sum),   e24.sum);
      chk("count24", 32'(b24.out_count), e24.cnt);
      chk("ovf24",   32'(b24.out_ovf),   e24.ovf);
      chk("sum16",   32'(b16.out_sum),   e16.sum);
      chk("count16", 32'(b16.out_count), e16.cnt);
      chk("ovf16",   32'(b16.out_ovf),   e16.ovf);
      if (h == hold) out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready24_after", 32'(b24.in_ready),  32'd1);
    chk("out_valid24_after", 32'(b24.out_valid), 32'd0);
    chk("in_ready16_after", 32'(b16.in_ready),  32'd1);
    chk("out_valid16_after", 32'(b16.out_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(b24.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(b24.out_valid), 32'd0);
    chk({tag, "_sum"},       32'(b24.out_sum),   32'd0);
    chk({tag, "_count"},     32'(b24.out_count), 32'd0);
    chk({tag, "_ovf"},       32'(b24.out_ovf),   32'd0);
    chk({tag, "_sum16"},     32'(b16.out_sum),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Single max-value beat; out_ready held high through the drain
    beat(8'd255, 8'd255, 1'b1);
    expect_out(0);

    // Back-to-back four-term frame: 2+12+30+56 = 100
    beat(8'd1, 8'd2, 1'b0);
    beat(8'd3, 8'd4, 1'b0);
    beat(8'd5, 8'd6, 1'b0);
    beat(8'd7, 8'd8, 1'b1);
    expect_out(0);

    // 130050 wraps the 16-bit instance to 64514 with ovf; next frame clears it
    beat(8'd255, 8'd255, 1'b0);
    beat(8'd255, 8'd255, 1'b1);
    expect_out(0);
    beat(8'd2, 8'd3, 1'b1);
    expect_out(0);

    // Backpressure: five cycles in OUT with out_ready low
    beat(8'd9, 8'd11, 1'b0);
    beat(8'd13, 8'd17, 1'b1);
    expect_out(5);

    // Bubbles with garbage operands: 100 + 400 = 500
    beat(8'd10, 8'd10, 1'b0);
    bubble();
    bubble();
    beat(8'd20, 8'd20, 1'b1);
    expect_out(0);

    // Count saturates at 255 while the sum keeps growing
    for (int i = 0; i < 260; i++) beat(8'd1, 8'd1, (i == 259));
    expect_out(0);

    // Asynchronous reset mid-frame discards partial sum and in-flight beats
    beat(8'd3, 8'd3, 1'b0);
    beat(8'd5, 8'd5, 1'b0);
    beat(8'd7, 8'd7, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    chk_reset_vals("midreset_hold");
    rst_n = 1'b1;
    m_sum = 0;
    m_cnt = 0;
    beat(8'd4, 8'd4, 1'b1);
    expect_out(0);

    chk("scoreboard_empty", 32'(q24.size() + q16.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
